// File: rtl/cl_pkg.sv
// Shared types and constants for the SD chart-metadata loader.
package cl_pkg;

    localparam int unsigned CL_SECTOR_BYTES     = 512;
    localparam int unsigned CL_WORDS_PER_SECTOR = 128;
    localparam int unsigned CL_BYTE_CNT_W       = 9;
    localparam int unsigned CL_SEC_IDX_W        = 16;
    localparam int unsigned CL_WORD_CNT_W       = 24;
    localparam logic [31:0] CL_END_MARKER       = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_ISSUE,
        ST_READ,
        ST_DONE,
        ST_ERR
    } cl_loader_state_t;

    // Byte address of a sector relative to a 512-byte aligned base.
    function automatic logic [31:0] cl_sector_addr(input logic [31:0] base,
                                                   input logic [CL_SEC_IDX_W-1:0] idx);
        return base + {7'd0, idx, 9'd0};
    endfunction

endpackage

// File: rtl/cl_byte_packer.sv
// Packs a byte stream into big-endian 32-bit words; first byte lands in [31:24].
module cl_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_i,
    input  logic        drop_i,
    output logic        word_done_c,
    output logic [31:0] word_c,
    output logic        word_vld_o,
    output logic [31:0] word_o
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        vld_q, vld_d;
    logic [31:0] word_q, word_d;

    assign word_c      = {shift_q, byte_i};
    assign word_done_c = byte_vld_i & ~clear_i & (cnt_q == 2'd3);

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        vld_d   = 1'b0;
        word_d  = word_q;
        if (clear_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (byte_vld_i) begin
            if (cnt_q == 2'd3) begin
                shift_d = '0;
                cnt_d   = '0;
                // A dropped word is consumed but never presented downstream.
                if (!drop_i) begin
                    vld_d  = 1'b1;
                    word_d = word_c;
                end
            end else begin
                shift_d = {shift_q[15:0], byte_i};
                cnt_d   = cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            word_q  <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            word_q  <= word_d;
        end
    end

    assign word_vld_o = vld_q;
    assign word_o     = word_q;

endmodule

// File: rtl/cl_sd_metadata_loader.sv
// Streams NUM_SECTORS sectors from sd_controller into 32-bit metadata words.
// CL_LOADER_END_MARKER_EN: an all-ones word ends the load after its sector drains.
module cl_sd_metadata_loader
    import cl_pkg::*;
#(
    parameter logic [31:0] BASE_ADR       = 32'h0000_0000,
    parameter int unsigned NUM_SECTORS    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk25,
    input  logic        reset_n,
    input  logic        start,
    input  logic        sd_ready,
    input  logic        sd_byte_available,
    input  logic [7:0]  sd_dout,
    output logic        sd_rd,
    output logic [31:0] sd_address,
    output logic        write_en,
    output logic [31:0] write_word,
    output logic [23:0] word_count,
    output logic        loaded,
    output logic        error
);

`ifdef CL_LOADER_END_MARKER_EN
    localparam bit MARKER_EN = 1'b1;
`else
    localparam bit MARKER_EN = 1'b0;
`endif

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CL_SEC_IDX_W-1:0] LAST_SEC = CL_SEC_IDX_W'(NUM_SECTORS - 1);
    localparam logic [CL_BYTE_CNT_W-1:0] LAST_BYTE = CL_BYTE_CNT_W'(CL_SECTOR_BYTES - 1);

    cl_loader_state_t state_q, state_d;
    logic [CL_SEC_IDX_W-1:0]  sec_q, sec_d;
    logic [CL_BYTE_CNT_W-1:0] byte_q, byte_d;
    logic [TMO_W-1:0]         tmo_q, tmo_d;
    logic [CL_WORD_CNT_W-1:0] wcnt_q, wcnt_d;
    logic [31:0]              addr_q, addr_d;
    logic                     bav_q;
    logic                     rd_q, rd_d;
    logic                     loaded_q, loaded_d;
    logic                     error_q, error_d;
    logic                     drain_q, drain_d;

    logic        byte_edge_c;
    logic        consume_c;
    logic        pack_vld_c;
    logic        word_done_c;
    logic [31:0] pack_word_c;
    logic        marker_hit_c;
    logic        active_c;

    // Level-high byte_available may last several cycles; only its rising edge counts.
    assign byte_edge_c  = sd_byte_available & ~bav_q;
    assign consume_c    = (state_q == ST_READ) & byte_edge_c & ~start;
    assign pack_vld_c   = consume_c & ~drain_q;
    assign marker_hit_c = MARKER_EN & word_done_c & (pack_word_c == CL_END_MARKER);
    assign active_c     = (state_q == ST_WAIT_RDY) || (state_q == ST_ISSUE) || (state_q == ST_READ);

    cl_byte_packer u_packer (
        .clk         (clk25),
        .rst_n       (reset_n),
        .clear_i     (start),
        .byte_vld_i  (pack_vld_c),
        .byte_i      (sd_dout),
        .drop_i      (marker_hit_c),
        .word_done_c (word_done_c),
        .word_c      (pack_word_c),
        .word_vld_o  (write_en),
        .word_o      (write_word)
    );

    always_comb begin
        state_d  = state_q;
        sec_d    = sec_q;
        byte_d   = byte_q;
        tmo_d    = tmo_q + TMO_W'(1);
        wcnt_d   = wcnt_q;
        rd_d     = 1'b0;
        loaded_d = loaded_q;
        error_d  = error_q;
        drain_d  = drain_q;

        if (word_done_c && !marker_hit_c) begin
            wcnt_d = wcnt_q + CL_WORD_CNT_W'(1);
        end

        if (start) begin
            state_d  = ST_WAIT_RDY;
            sec_d    = '0;
            byte_d   = '0;
            tmo_d    = '0;
            wcnt_d   = '0;
            loaded_d = 1'b0;
            error_d  = 1'b0;
            drain_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: tmo_d = '0;
                ST_WAIT_RDY: begin
                    if (sd_ready) state_d = ST_READ == ST_READ ? ST_ISSUE : ST_ISSUE;
                end
                ST_ISSUE: begin
                    rd_d = 1'b1;
                    if (rd_q && !sd_ready) begin
                        rd_d    = 1'b0;
                        state_d = ST_READ;
                    end
                end
                ST_READ: begin
                    if (consume_c) begin
                        tmo_d  = '0;
                        byte_d = byte_q + CL_BYTE_CNT_W'(1);
                        if (marker_hit_c) drain_d = 1'b1;
                        if (byte_q == LAST_BYTE) begin
                            byte_d = '0;
                            if (sec_q == LAST_SEC || drain_q || marker_hit_c) begin
                                state_d = ST_DONE;
                            end else begin
                                sec_d   = sec_q + CL_SEC_IDX_W'(1);
                                state_d = ST_WAIT_RDY;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    tmo_d    = '0;
                    loaded_d = 1'b1;
                end
                ST_ERR:  tmo_d = '0;
                default: state_d = ST_IDLE;
            endcase

            // Stall watchdog: only fires when no progress was made this cycle.
            if (active_c && state_d == state_q && !consume_c && tmo_q == TMO_LAST) begin
                state_d = ST_ERR;
                error_d = 1'b1;
                rd_d    = 1'b0;
            end
            if (state_d != state_q) tmo_d = '0;
        end

        addr_d = cl_sector_addr(BASE_ADR, sec_d);
    end

    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            sec_q    <= '0;
            byte_q   <= '0;
            tmo_q    <= '0;
            wcnt_q   <= '0;
            addr_q   <= BASE_ADR;
            bav_q    <= 1'b0;
            rd_q     <= 1'b0;
            loaded_q <= 1'b0;
            error_q  <= 1'b0;
            drain_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sec_q    <= sec_d;
            byte_q   <= byte_d;
            tmo_q    <= tmo_d;
            wcnt_q   <= wcnt_d;
            addr_q   <= addr_d;
            bav_q    <= sd_byte_available;
            rd_q     <= rd_d;
            loaded_q <= loaded_d;
            error_q  <= error_d;
            drain_q  <= drain_d;
        end
    end

    assign sd_rd      = rd_q;
    assign sd_address = addr_q;
    assign word_count = wcnt_q;
    assign loaded     = loaded_q;
    assign error      = error_q;

endmodule

// File: tb/tb_cl_sd_metadata_loader.sv
// Self-checking bench for cl_sd_metadata_loader with a behavioural SD card model.
module tb_cl_sd_metadata_loader;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam int NSEC = 2;
    localparam int TMO  = 100;

    logic        clk25 = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        sd_ready = 1'b1;
    logic        sd_byte_available = 1'b0;
    logic [7:0]  sd_dout = 8'h00;
    logic        sd_rd;
    logic [31:0] sd_address;
    logic        write_en;
    logic [31:0] write_word;
    logic [23:0] word_count;
    logic        loaded;
    logic        error;

    cl_sd_metadata_loader #(
        .BASE_ADR       (BASE),
        .NUM_SECTORS    (NSEC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk25             (clk25),
        .reset_n           (reset_n),
        .start             (start),
        .sd_ready          (sd_ready),
        .sd_byte_available (sd_byte_available),
        .sd_dout           (sd_dout),
        .sd_rd             (sd_rd),
        .sd_address        (sd_address),
        .write_en          (write_en),
        .write_word        (write_word),
        .word_count        (word_count),
        .loaded            (loaded),
        .error             (error)
    );

    always #20 clk25 = ~clk25;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0]  src [1024];
    logic [31:0] got_q [$];
    logic [31:0] addr_q [$];
    int          late_wr = 0;
    logic        rd_prev = 1'b0;

    // Collects emitted words and the address seen at each read request.
    always @(negedge clk25) begin
        if (write_en === 1'b1) begin
            got_q.push_back(write_word);
            if (loaded === 1'b1) late_wr++;
        end
        if (sd_rd === 1'b1 && rd_prev !== 1'b1) addr_q.push_back(sd_address);
        rd_prev = sd_rd;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] exp_word(input int w);
        return {src[4*w], src[4*w+1], src[4*w+2], src[4*w+3]};
    endfunction

    function automatic logic [31:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic clear_mon();
        got_q.delete();
        addr_q.delete();
        late_wr = 0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 1024; i++) src[i] = 8'($urandom_range(254, 0));
    endtask

    task automatic pulse_start();
        @(posedge clk25); #1 start = 1'b1;
        @(posedge clk25); #1 start = 1'b0;
    endtask

    // SD card model: answers one read request, then delivers bytes [first,last).
    task automatic serve(input int sec, input int hold, input int first, input int last,
                         output bit ok);
        int n;
        int h;
        ok = 1'b1;
        if (first == 0) begin
            n = 0;
            while (sd_rd !== 1'b1 && n < 400) begin
                @(negedge clk25);
                n++;
            end
            if (sd_rd !== 1'b1) begin
                ok = 1'b0;
                return;
            end
            @(posedge clk25); #1 sd_ready = 1'b0;
            repeat (2) @(posedge clk25);
            #1;
        end
        for (int i = first; i < last; i++) begin
            sd_dout = src[sec*512 + i];
            sd_byte_available = 1'b1;
            h = (hold == 0) ? int'($urandom_range(3, 1)) : hold;
            repeat (h) @(posedge clk25);
            #1 sd_byte_available = 1'b0;
            sd_dout = 8'($urandom);
            repeat ($urandom_range(2, 1)) @(posedge clk25);
            #1;
        end
        if (last == 512) sd_ready = 1'b1;
    endtask

    task automatic wait_loaded(output bit ok);
        int n;
        n = 0;
        while (loaded !== 1'b1 && n < 300) begin
            @(negedge clk25);
            n++;
        end
        ok = (loaded === 1'b1);
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk25);
        n_vec++; if (sd_rd !== 1'b0) begin n_err++; $display("FAIL reset_sd_rd got %b want 0", sd_rd); end
        n_vec++; if (write_en !== 1'b0) begin n_err++; $display("FAIL reset_write_en got %b want 0", write_en); end
        n_vec++; if (loaded !== 1'b0) begin n_err++; $display("FAIL reset_loaded got %b want 0", loaded); end
        n_vec++; if (error !== 1'b0) begin n_err++; $display("FAIL reset_error got %b want 0", error); end
        n_vec++; if (word_count !== 24'd0) begin n_err++; $display("FAIL reset_word_count got %0d want 0", word_count); end
        n_vec++; if (write_word !== 32'd0) begin n_err++; $display("FAIL reset_write_word got %h want 0", write_word); end
        n_vec++; if (sd_address !== BASE) begin n_err++; $display("FAIL reset_sd_address got %h want %h", sd_address, BASE); end
        #3 reset_n = 1'b1;
        repeat (2) @(negedge clk25);
    endtask

    task automatic test_full_load();
        bit ok0, ok1, okl;
        for (int i = 0; i < 512; i++) src[i] = 8'(i);
        for (int i = 512; i < 1024; i++) src[i] = 8'($urandom);
        clear_mon();
        pulse_start();
        serve(0, 1, 0, 512, ok0);
        serve(1, 1, 0, 512, ok1);
        wait_loaded(okl);
        n_vec++; if ({ok0, ok1} !== 2'b11) begin n_err++; $display("FAIL full_rd_handshake got %b want 11", {ok0, ok1}); end
        n_vec++; if (!okl) begin n_err++; $display("FAIL full_loaded got %b want 1", loaded); end
        n_vec++; if (got_q.size() !== 256) begin n_err++; $display("FAIL full_write_count got %0d want 256", got_q.size()); end
        n_vec++; if (got_at(0) !== 32'h0001_0203) begin n_err++; $display("FAIL full_first_word got %h want 00010203", got_at(0)); end
        n_vec++; if (got_at(127) !== 32'hFCFD_FEFF) begin n_err++; $display("FAIL full_last_word_s0 got %h want fcfdfeff", got_at(127)); end
        for (int w = 0; w < 256; w++) begin
            n_vec++;
            if (got_at(w) !== exp_word(w)) begin n_err++; $display("FAIL full_word[%0d] got %h want %h", w, got_at(w), exp_word(w)); end
        end
        n_vec++; if (addr_q.size() !== 2) begin n_err++; $display("FAIL full_rd_count got %0d want 2", addr_q.size()); end
        n_vec++; if (addr_q.size() > 0 && addr_q[0] !== BASE) begin n_err++; $display("FAIL full_addr0 got %h want %h", addr_q[0], BASE); end
        n_vec++; if (addr_q.size() > 1 && addr_q[1] !== BASE + 32'd512) begin n_err++; $display("FAIL full_addr1 got %h want %h", addr_q[1], BASE + 32'd512); end
        n_vec++; if (word_count !== 24'd256) begin n_err++; $display("FAIL full_word_count got %0d want 256", word_count); end
        n_vec++; if (late_wr !== 0) begin n_err++; $display("FAIL full_write_after_loaded got %0d want 0", late_wr); end
        n_vec++; if (error !== 1'b0) begin n_err++; $display("FAIL full_error got %b want 0", error); end
    endtask

    task automatic test_long_pulse();
        bit ok0, ok1, okl;
        fill_random();
        clear_mon();
        pulse_start();
        serve(0, 3, 0, 512, ok0);
        serve(1, 3, 0, 512, ok1);
        wait_loaded(okl);
        n_vec++; if (!(ok0 && ok1 && okl)) begin n_err++; $display("FAIL long_handshake_loaded got %b%b%b want 111", ok0, ok1, okl); end
        n_vec++; if (got_q.size() !== 256) begin n_err++; $display("FAIL long_write_count got %0d want 256", got_q.size()); end
        for (int w = 0; w < 256; w++) begin
            n_vec++;
            if (got_at(w) !== exp_word(w)) begin n_err++; $display("FAIL long_word[%0d] got %h want %h", w, got_at(w), exp_word(w)); end
        end
        n_vec++; if (word_count !== 24'd256) begin n_err++; $display("FAIL long_word_count got %0d want 256", word_count); end
    endtask

    task automatic test_timeout();
        bit ok0, ok1, okl;
        sd_ready = 1'b0;
        clear_mon();
        pulse_start();
        repeat (90) @(negedge clk25);
        n_vec++; if (error !== 1'b0) begin n_err++; $display("FAIL tmo_early_error got %b want 0", error); end
        repeat (20) @(negedge clk25);
        n_vec++; if (error !== 1'b1) begin n_err++; $display("FAIL tmo_error got %b want 1", error); end
        n_vec++; if (sd_rd !== 1'b0) begin n_err++; $display("FAIL tmo_sd_rd got %b want 0", sd_rd); end
        n_vec++; if (loaded !== 1'b0) begin n_err++; $display("FAIL tmo_loaded got %b want 0", loaded); end
        n_vec++; if (addr_q.size() !== 0) begin n_err++; $display("FAIL tmo_rd_count got %0d want 0", addr_q.size()); end
        sd_ready = 1'b1;
        fill_random();
        clear_mon();
        pulse_start();
        @(negedge clk25);
        n_vec++; if (error !== 1'b0) begin n_err++; $display("FAIL tmo_error_cleared got %b want 0", error); end
        serve(0, 0, 0, 512, ok0);
        serve(1, 0, 0, 512, ok1);
        wait_loaded(okl);
        n_vec++; if (!(ok0 && ok1 && okl)) begin n_err++; $display("FAIL tmo_recover_loaded got %b%b%b want 111", ok0, ok1, okl); end
        n_vec++; if (word_count !== 24'd256) begin n_err++; $display("FAIL tmo_recover_count got %0d want 256", word_count); end
        for (int w = 0; w < 256; w++) begin
            n_vec++;
            if (got_at(w) !== exp_word(w)) begin n_err++; $display("FAIL tmo_word[%0d] got %h want %h", w, got_at(w), exp_word(w)); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok0, ok1, okl;
        fill_random();
        clear_mon();
        pulse_start();
        serve(0, 1, 0, 6, ok0);
        #5 reset_n = 1'b0;
        #2;
        n_vec++; if (word_count !== 24'd0) begin n_err++; $display("FAIL rst_mid_word_count got %0d want 0", word_count); end
        n_vec++; if (write_word !== 32'd0) begin n_err++; $display("FAIL rst_mid_write_word got %h want 0", write_word); end
        n_vec++; if ({sd_rd, write_en, loaded, error} !== 4'b0000) begin n_err++; $display("FAIL rst_mid_flags got %b want 0000", {sd_rd, write_en, loaded, error}); end
        n_vec++; if (sd_address !== BASE) begin n_err++; $display("FAIL rst_mid_addr got %h want %h", sd_address, BASE); end
        #5 reset_n = 1'b1;
        sd_ready = 1'b1;
        fill_random();
        repeat (2) @(negedge clk25);
        clear_mon();
        pulse_start();
        serve(0, 0, 0, 512, ok0);
        serve(1, 0, 0, 512, ok1);
        wait_loaded(okl);
        n_vec++; if (!(ok0 && ok1 && okl)) begin n_err++; $display("FAIL rst_mid_loaded got %b%b%b want 111", ok0, ok1, okl); end
        n_vec++; if (got_at(0) !== exp_word(0)) begin n_err++; $display("FAIL rst_mid_first_word got %h want %h", got_at(0), exp_word(0)); end
        n_vec++; if (got_q.size() !== 256) begin n_err++; $display("FAIL rst_mid_write_count got %0d want 256", got_q.size()); end
        for (int w = 1; w < 256; w++) begin
            n_vec++;
            if (got_at(w) !== exp_word(w)) begin n_err++; $display("FAIL rst_mid_word[%0d] got %h want %h", w, got_at(w), exp_word(w)); end
        end
    endtask

    task automatic test_end_marker();
        bit ok0, ok1, okl;
        fill_random();
        for (int i = 16; i < 20; i++) src[i] = 8'hFF;
        clear_mon();
        pulse_start();
        serve(0, 1, 0, 511, ok0);
        repeat (5) @(negedge clk25);
        n_vec++; if (loaded !== 1'b0) begin n_err++; $display("FAIL marker_loaded_before_drain got %b want 0", loaded); end
        serve(0, 1, 511, 512, ok1);
`ifdef CL_LOADER_END_MARKER_EN
        wait_loaded(okl);
        n_vec++; if (!(ok0 && okl)) begin n_err++; $display("FAIL marker_loaded got %b%b want 11", ok0, okl); end
        n_vec++; if (got_q.size() !== 4) begin n_err++; $display("FAIL marker_write_count got %0d want 4", got_q.size()); end
        for (int w = 0; w < 4; w++) begin
            n_vec++;
            if (got_at(w) !== exp_word(w)) begin n_err++; $display("FAIL marker_word[%0d] got %h want %h", w, got_at(w), exp_word(w)); end
        end
        n_vec++; if (word_count !== 24'd4) begin n_err++; $display("FAIL marker_word_count got %0d want 4", word_count); end
        repeat (10) @(negedge clk25);
        n_vec++; if (addr_q.size() !== 1) begin n_err++; $display("FAIL marker_rd_count got %0d want 1", addr_q.size()); end
`else
        serve(1, 1, 0, 512, ok1);
        wait_loaded(okl);
        n_vec++; if (!(ok0 && ok1 && okl)) begin n_err++; $display("FAIL marker_loaded got %b%b%b want 111", ok0, ok1, okl); end
        n_vec++; if (got_q.size() !== 256) begin n_err++; $display("FAIL marker_write_count got %0d want 256", got_q.size()); end
        n_vec++; if (got_at(4) !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL marker_word4 got %h want ffffffff", got_at(4)); end
        for (int w = 0; w < 256; w++) begin
            n_vec++;
            if (got_at(w) !== exp_word(w)) begin n_err++; $display("FAIL marker_word[%0d] got %h want %h", w, got_at(w), exp_word(w)); end
        end
        n_vec++; if (word_count !== 24'd256) begin n_err++; $display("FAIL marker_word_count got %0d want 256", word_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_long_pulse();
        test_timeout();
        test_reset_mid();
        test_end_marker();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
